// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the 3-digit common-anode scan driver: segment codes,
// blank patterns and the scan index encodings.
package seg7_scan_driver_pkg;

  localparam int NUM_DIG = 3;

  localparam logic [1:0] IDX_U = 2'd0;
  localparam logic [1:0] IDX_D = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;

  // Active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [2:0] AN_OFF   = 3'b111;

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 show a dash.
module bcd_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Captures three BCD digits and time-multiplexes them onto a common-anode display.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zeros in the tens/hundreds slots.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] dig_u,
  input  logic [3:0] dig_d,
  input  logic [3:0] dig_c,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       tick
);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       idx_reg, idx_next;
  logic             tick_reg;
  logic [3:0]       cap_u_reg, cap_d_reg, cap_c_reg;
  logic [2:0]       an_reg, an_next, an_sel;
  logic [6:0]       seg_reg, seg_next, seg_raw;
  logic [3:0]       digit_sel;
  logic             wrap;
  logic             blank;

  assign wrap = (cnt_reg == CNT_W'(CLK_DIV - 1));

  always_comb begin
    cnt_next = wrap ? '0 : cnt_reg + CNT_W'(1);
    idx_next = idx_reg;
    // An illegal index recovers to units on the next edge regardless of the prescaler
    if (idx_reg > IDX_C)
      idx_next = IDX_U;
    else if (wrap)
      idx_next = (idx_reg == IDX_C) ? IDX_U : idx_reg + 2'd1;
  end

  always_comb begin
    digit_sel = cap_u_reg;
    case (idx_reg)
      IDX_D:   digit_sel = cap_d_reg;
      IDX_C:   digit_sel = cap_c_reg;
      default: digit_sel = cap_u_reg;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (digit_sel),
    .seg (seg_raw)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign blank = ((idx_reg == IDX_C) && (cap_c_reg == 4'd0)) ||
                 ((idx_reg == IDX_D) && (cap_c_reg == 4'd0) && (cap_d_reg == 4'd0));
`else
  assign blank = 1'b0;
`endif

  for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_an
    assign an_sel[gi] = (idx_reg != 2'(gi));
  end

  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    if (en && !blank && (an_sel != AN_OFF)) begin
      an_next  = an_sel;
      seg_next = seg_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      idx_reg   <= IDX_U;
      tick_reg  <= 1'b0;
      cap_u_reg <= 4'd0;
      cap_d_reg <= 4'd0;
      cap_c_reg <= 4'd0;
      an_reg    <= AN_OFF;
      seg_reg   <= SEG_OFF;
    end else begin
      cnt_reg  <= cnt_next;
      idx_reg  <= idx_next;
      tick_reg <= wrap;
      an_reg   <= an_next;
      seg_reg  <= seg_next;
      if (load) begin
        cap_u_reg <= dig_u;
        cap_d_reg <= dig_d;
        cap_c_reg <= dig_c;
      end
    end
  end

  assign an   = an_reg;
  assign seg  = seg_reg;
  assign tick = tick_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with CLK_DIV=4 and a cycle-level reference model.
module tb_seg7_scan_driver;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       en = 1'b0;
  logic [3:0] dig_u = 4'd0, dig_d = 4'd0, dig_c = 4'd0;
  logic [2:0] an;
  logic [6:0] seg;
  logic       tick;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.CLK_DIV(DIV), .CNT_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .en    (en),
    .dig_u (dig_u),
    .dig_d (dig_d),
    .dig_c (dig_c),
    .an    (an),
    .seg   (seg),
    .tick  (tick)
  );

  function automatic logic [6:0] ref_code(int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic check(string name, logic [6:0] act, logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k edges since reset release gives slot (k/DIV)%3 and tick on every DIV-th edge
  int         k;
  int         m_dig [3];
  int         slot;
  bit         show;
  bit         m_valid = 1'b0;
  logic [2:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_tick;

  always @(posedge clk) begin
    if (rst) begin
      k = 0;
      m_dig[0] = 0; m_dig[1] = 0; m_dig[2] = 0;
      exp_an = 3'b111; exp_seg = 7'b1111111; exp_tick = 1'b0;
      m_valid = 1'b1;
    end else begin
      slot = (k / DIV) % 3;
      show = en;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (slot == 2 && m_dig[2] == 0) show = 1'b0;
      if (slot == 1 && m_dig[2] == 0 && m_dig[1] == 0) show = 1'b0;
`endif
      if (show) begin
        exp_an  = ~(3'b001 << slot);
        exp_seg = ref_code(m_dig[slot]);
      end else begin
        exp_an  = 3'b111;
        exp_seg = 7'b1111111;
      end
      exp_tick = ((k + 1) % DIV) == 0;
      if (load) begin
        m_dig[0] = int'(dig_u); m_dig[1] = int'(dig_d); m_dig[2] = int'(dig_c);
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_an", {4'b0, an}, {4'b0, exp_an});
      check("model_seg", seg, exp_seg);
      check("model_tick", {6'b0, tick}, {6'b0, exp_tick});
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_an(logic [2:0] target, string name);
    for (int i = 0; i < 30 && an !== target; i++) step(1);
    check(name, {4'b0, an}, {4'b0, target});
  endtask

  task automatic load_digits(logic [3:0] u, logic [3:0] d, logic [3:0] c);
    dig_u = u; dig_d = d; dig_c = c;
    load = 1'b1;
    step(1);
    load = 1'b0;
    dig_u = 4'($urandom); dig_d = 4'($urandom); dig_c = 4'($urandom);
    $display("load u=%0d d=%0d c=%0d", u, d, c);
  endtask

  int first_tick;
  int dur;

  initial begin
    step(3);
    check("rst_an", {4'b0, an}, 7'b0000111);
    check("rst_seg", seg, 7'b1111111);
    check("rst_tick", {6'b0, tick}, 7'd0);
    rst = 1'b0;
    en  = 1'b1;
    first_tick = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (tick === 1'b1 && first_tick == 0) first_tick = i;
    end
    check("first_tick", 7'(first_tick), 7'd4);

    load_digits(4'd5, 4'd5, 4'd2);
    wait_an(3'b011, "sync_c");
    wait_an(3'b110, "slot_u_an");
    check("slot_u_seg", seg, 7'b0010010);
    wait_an(3'b101, "slot_d_an");
    check("slot_d_seg", seg, 7'b0010010);
    wait_an(3'b011, "slot_c_an");
    check("slot_c_seg", seg, 7'b0100100);
    dur = 0;
    while (an === 3'b011 && dur < 20) begin
      dur++;
      step(1);
    end
    check("slot_len", 7'(dur), 7'd4);
    check("wrap_u", {4'b0, an}, 7'b0000110);

    load_digits(4'hC, 4'd5, 4'd2);
    wait_an(3'b101, "dash_sync");
    wait_an(3'b110, "dash_an");
    check("dash_seg", seg, 7'b0111111);

    load_digits(4'd7, 4'd0, 4'd0);
    step(13);
    wait_an(3'b110, "lz_u_an");
    check("lz_u_seg", seg, 7'b1111000);
    step(4);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    check("lz_d_an", {4'b0, an}, 7'b0000111);
    check("lz_d_seg", seg, 7'b1111111);
    step(4);
    check("lz_c_an", {4'b0, an}, 7'b0000111);
    check("lz_c_seg", seg, 7'b1111111);
`else
    check("lz_d_an", {4'b0, an}, 7'b0000101);
    check("lz_d_seg", seg, 7'b1000000);
    step(4);
    check("lz_c_an", {4'b0, an}, 7'b0000011);
    check("lz_c_seg", seg, 7'b1000000);
`endif

    load_digits(4'd3, 4'd2, 4'd1);
    wait_an(3'b011, "en_sync");
    wait_an(3'b110, "en_u_start");
    step(1);
    en = 1'b0;
    step(1);
    check("en_off_an", {4'b0, an}, 7'b0000111);
    check("en_off_seg", seg, 7'b1111111);
    en = 1'b1;
    step(1);
    check("en_on_an", {4'b0, an}, 7'b0000110);
    check("en_on_seg", seg, 7'b0110000);
    step(1);
    check("en_next_an", {4'b0, an}, 7'b0000101);
    check("en_next_seg", seg, 7'b0100100);

    wait_an(3'b011, "sim_sync");
    wait_an(3'b110, "sim_u_start");
    step(2);
    dig_u = 4'd8; dig_d = 4'd6; dig_c = 4'd9;
    load = 1'b1;
    step(1);
    load = 1'b0;
    $display("load u=8 d=6 c=9 on scan advance");
    step(1);
    check("sim_an", {4'b0, an}, 7'b0000101);
    check("sim_seg", seg, 7'b0000010);
    rst = 1'b1;
    step(1);
    check("mid_rst_an", {4'b0, an}, 7'b0000111);
    check("mid_rst_seg", seg, 7'b1111111);
    check("mid_rst_tick", {6'b0, tick}, 7'd0);
    rst = 1'b0;
    step(1);
    check("post_rst_an", {4'b0, an}, 7'b0000110);
    check("post_rst_seg", seg, 7'b1000000);
    step(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
